multi_counter: RTL
==================

MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels, minimum 1.
REQ-002 Parameter CNT_W, default 8: width of each channel's count, minimum 2.
REQ-003 Parameter PRESC_W, default 4: width of the shared prescaler.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 clear  input  NUM_CH  per-channel synchronous clear.
REQ-007 count_enable  input  NUM_CH  per-channel count enable.
REQ-008 load  input  NUM_CH  per-channel load strobe.
REQ-009 load_val  input  NUM_CH*CNT_W  per-channel load value; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-010 rollover_val  input  NUM_CH*CNT_W  per-channel terminal value, packed the same way as load_val.
REQ-011 mode  input  NUM_CH*2  per-channel mode: 00 UP_WRAP, 01 UP_ONESHOT, 10 DOWN_WRAP, 11 DOWN_ONESHOT.
REQ-012 prescale_val  input  PRESC_W  prescaler terminal value; port exists only when the macro in the Configuration section is defined.
REQ-013 count_out  output  NUM_CH*CNT_W  registered per-channel count.
REQ-014 rollover_flag  output  NUM_CH  registered one-cycle pulse per channel.
REQ-015 done  output  NUM_CH  registered level; high while a one-shot channel is in DONE.

Function
REQ-016 Channel tick = count_enable[i] & presc_tick; the channel advances only on a cycle where its tick is high.
REQ-017 Per-channel update priority: RST > clear > load > tick > hold.
REQ-018 Up modes, on tick: if count == rollover_val then next count = 0, else next count = count+1 modulo 2^CNT_W.
REQ-019 Down modes, on tick: if count == 0 then next count = rollover_val, else next count = count-1.
REQ-020 Terminal event = a tick that wraps the count per REQ-018/REQ-019; rollover_flag[i] is high for exactly the following cycle only.
REQ-021 Each channel has states RUN and DONE; a terminal event in a ONESHOT mode moves the channel RUN->DONE.
REQ-022 On entry to DONE, count holds the terminal value (rollover_val for up, 0 for down) instead of wrapping, rollover_flag still pulses, and done=1.
REQ-023 In DONE, ticks are ignored; clear or load returns the channel to RUN.
REQ-024 Clear: count = 0 in up modes, rollover_val in down modes; state = RUN; no flag.
REQ-025 Load: count = load_val; state = RUN; no flag, even when load_val equals the terminal value.
REQ-026 A mode change takes effect on the next tick without altering count; if a DONE channel is switched to a WRAP mode, it stays in DONE until clear or load.
REQ-027 With rollover_val = 0 in up modes, every tick is a terminal event; count stays 0.
REQ-028 In up modes with count > rollover_val, the count runs to 2^CNT_W-1, wraps to 0 without a flag, and continues.
REQ-029 Channels are fully independent; simultaneous events on different channels do not interact.

Reset
REQ-030 RST=1 at a rising edge sets every count_out to 0, rollover_flag to 0, done to 0, every state to RUN, and the prescaler to 0, overriding all other inputs, including mid-count and in DONE.

Configuration
REQ-031 With MULTI_COUNTER_PRESCALE_EN defined: a shared prescaler counts 0..prescale_val and then returns to 0.
REQ-032 With MULTI_COUNTER_PRESCALE_EN defined: presc_tick=1 in cycles where prescaler == prescale_val, so prescale_val=0 gives a tick every cycle.
REQ-033 With MULTI_COUNTER_PRESCALE_EN defined: the prescaler free-runs, is unaffected by clear and load, and is reset only by RST.
REQ-034 Without MULTI_COUNTER_PRESCALE_EN: presc_tick is constant 1, no prescaler logic exists, and the prescale_val port is absent.

Structure
REQ-035 Package multi_counter_pkg holds the cnt_mode_e enum (2 bits, encodings per REQ-011) and the chan_state_e enum (RUN, DONE).
REQ-036 One channel is implemented in sub-module counter_chan (parameter CNT_W), instantiated NUM_CH times by a generate loop; the prescaler lives in the top level.

Verification
REQ-037 CNT_W=8, UP_WRAP, rollover_val=3, enable held: count sequence 0,1,2,3,0,1; rollover_flag high only in the cycle count_out first shows 0 after 3.
REQ-038 DOWN_ONESHOT, load_val=2, then enable: count 2,1,0, then holds 0; done=1 and one flag pulse; a later clear gives count=rollover_val and done=0.
REQ-039 Same cycle clear=1, load=1, tick=1 with count=5: count=0 (up mode); then RST together with load: count=0.
REQ-040 With the macro defined, prescale_val=2 and UP_WRAP: count increments once every 3 cycles; prescale_val=0 increments every cycle.
REQ-041 NUM_CH=4, each channel in a different mode, with random per-channel enables: each channel matches an independent scoreboard model, and RST mid-run zeroes all outputs on the next edge.

Source files
------------

// File: rtl/multi_counter_pkg.sv
// Shared types for the multi-channel counter: count modes, channel states
// and small mode-decoding helpers.
package multi_counter_pkg;

    typedef enum logic [1:0] {
        UP_WRAP      = 2'b00,
        UP_ONESHOT   = 2'b01,
        DOWN_WRAP    = 2'b10,
        DOWN_ONESHOT = 2'b11
    } cnt_mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } chan_state_e;

    function automatic logic mode_is_down(input cnt_mode_e m);
        return m[1];
    endfunction

    function automatic logic mode_is_oneshot(input cnt_mode_e m);
        return m[0];
    endfunction

endpackage

// File: rtl/multi_counter_chan.sv
// One counter channel: up/down, wrap/one-shot, with clear, load and a
// one-cycle rollover pulse. Priority is rst > clear > load > tick.
module counter_chan
    import multi_counter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             tick,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] rollover_val,
    input  cnt_mode_e        mode,
    output logic [CNT_W-1:0] count,
    output logic             rollover_flag,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic             flag_reg;
    chan_state_e      state_reg;

    logic             is_down;
    logic             is_oneshot;
    logic             at_terminal;
    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] end_val;
    logic [CNT_W-1:0] stepped;

    // start_val is both the clear value and the value a wrap lands on;
    // end_val is where a one-shot parks.
    assign is_down     = mode_is_down(mode);
    assign is_oneshot  = mode_is_oneshot(mode);
    assign start_val   = is_down ? rollover_val : '0;
    assign end_val     = is_down ? '0 : rollover_val;
    assign at_terminal = is_down ? (count_reg == '0) : (count_reg == rollover_val);
    assign stepped     = is_down ? (count_reg - ONE) : (count_reg + ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
            state_reg <= RUN;
        end else begin
            flag_reg <= 1'b0;
            if (clear) begin
                count_reg <= start_val;
                state_reg <= RUN;
            end else if (load) begin
                count_reg <= load_val;
                state_reg <= RUN;
            end else if (tick && state_reg == RUN) begin
                if (at_terminal) begin
                    flag_reg <= 1'b1;
                    if (is_oneshot) begin
                        count_reg <= end_val;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= start_val;
                    end
                end else begin
                    count_reg <= stepped;
                end
            end
        end
    end

    assign count         = count_reg;
    assign rollover_flag = flag_reg;
    assign done          = (state_reg == DONE);

endmodule

// File: rtl/multi_counter.sv
// NUM_CH independent counter channels sharing one tick source. Define
// MULTI_COUNTER_PRESCALE_EN to add the shared prescaler and prescale_val port.
module multi_counter
    import multi_counter_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic                    clk,
    input  logic                    RST,
`ifdef MULTI_COUNTER_PRESCALE_EN
    input  logic [PRESC_W-1:0]      prescale_val,
`endif
    input  logic [NUM_CH-1:0]       clear,
    input  logic [NUM_CH-1:0]       count_enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] load_val,
    input  logic [NUM_CH*CNT_W-1:0] rollover_val,
    input  logic [NUM_CH*2-1:0]     mode,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]       rollover_flag,
    output logic [NUM_CH-1:0]       done
);

    logic presc_tick;

`ifdef MULTI_COUNTER_PRESCALE_EN
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_reg;

    // Free-running: only RST restarts it, channel clear/load never do.
    always_ff @(posedge clk) begin
        if (RST) begin
            presc_reg <= '0;
        end else if (presc_reg == prescale_val) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PRESC_ONE;
        end
    end

    assign presc_tick = (presc_reg == prescale_val);
`else
    // Always true; PRESC_W only shapes hardware when the prescaler is built in.
    assign presc_tick = (PRESC_W > 0);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            counter_chan #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk          (clk),
                .rst          (RST),
                .clear        (clear[gi]),
                .load         (load[gi]),
                .tick         (count_enable[gi] & presc_tick),
                .load_val     (load_val[gi*CNT_W +: CNT_W]),
                .rollover_val (rollover_val[gi*CNT_W +: CNT_W]),
                .mode         (cnt_mode_e'(mode[gi*2 +: 2])),
                .count        (count_out[gi*CNT_W +: CNT_W]),
                .rollover_flag(rollover_flag[gi]),
                .done         (done[gi])
            );
        end
    endgenerate

endmodule
